// File: rtl/lpc_exc_pkg.sv
// lpc_exc_pkg: shared constants, types and helpers for the LPC excitation generator
package lpc_exc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Right-shifting Galois masks: x^16+x^14+x^13+x^11+1 and x^24+x^23+x^22+x^17+1
    localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] LFSR_TAPS_24 = 32'h00E1_0000;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    function automatic logic [31:0] lfsr_taps(input int w);
        return (w == 24) ? LFSR_TAPS_24 : LFSR_TAPS_16;
    endfunction

    // Clamp x into the signed range of a w-bit value
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

endpackage

// File: rtl/lfsr_noise.sv
// lfsr_noise: Galois LFSR noise source, one step per sample strobe
module lfsr_noise
    import lpc_exc_pkg::*;
#(
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = LFSR_W'(LFSR_SEED_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] lfsr_out
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] s;

    // Advance on each strobe; a lock-up in the all-zero state recovers to the seed
    always_ff @(posedge clk) begin
        if (!rst)
            s <= LFSR_SEED;
        else if (en)
            s <= (s == '0) ? LFSR_SEED : (s >> 1) ^ (s[0] ? TAPS : '0);
    end

    assign lfsr_out = s;

endmodule

// File: rtl/lpc_excitation_gen.sv
// lpc_excitation_gen: voiced impulse-train / unvoiced noise excitation for LPC synthesis
module lpc_excitation_gen
    import lpc_exc_pkg::*;
#(
    parameter int                 DATA_W    = 16,
    parameter int                 CNT_W     = 16,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = LFSR_W'(LFSR_SEED_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     v,
    input  logic [CNT_W-1:0]         pulserate,
    input  logic [CNT_W-1:0]         lpcrate,
    input  logic signed [DATA_W-1:0] gain,
    output logic signed [DATA_W-1:0] exc_out,
    output logic                     exc_valid,
    output logic                     vout,
    output logic                     frame_start
);

    logic [LFSR_W-1:0]         lfsr;
    logic [CNT_W-1:0]          frame_cnt, pitch_cnt, prate_s;
    logic                      v_s;
    logic signed [DATA_W-1:0]  gain_s;

    logic                      bnd, v_n, pulse;
    logic [CNT_W-1:0]          pr_n, pc, pc_nxt, fc_nxt;
    logic signed [DATA_W-1:0]  g_n, noise, exc_n;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [63:0]        sh;

    lfsr_noise #(.LFSR_W(LFSR_W), .LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .lfsr_out (lfsr)
    );

    // Boundary latching is resolved first so the sample uses the new frame's parameters
    always_comb begin
        bnd    = (frame_cnt == '0);
        v_n    = bnd ? v : v_s;
        g_n    = bnd ? gain : gain_s;
        pr_n   = bnd ? pulserate : prate_s;
        fc_nxt = bnd ? ((lpcrate == '0) ? '0 : lpcrate - CNT_W'(1)) : frame_cnt - CNT_W'(1);
        pc     = (bnd && v && !v_s) ? '0 : pitch_cnt;
        pulse  = (pc == '0);
        pc_nxt = !v_n ? pitch_cnt : pulse ? ((pr_n == '0) ? '0 : pr_n - CNT_W'(1)) : pc - CNT_W'(1);
        prod   = $signed(lfsr[DATA_W-1:0]) * g_n;
        sh     = prod >>> (DATA_W - 1);
        noise  = DATA_W'(sat(sh, DATA_W));
        exc_n  = v_n ? (pulse ? g_n : '0) : noise;
    end

    // Counters, shadow registers and the registered output sample
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt   <= '0;
            pitch_cnt   <= '0;
            v_s         <= 1'b0;
            prate_s     <= '0;
            gain_s      <= '0;
            exc_out     <= '0;
            exc_valid   <= 1'b0;
            vout        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            exc_valid   <= en;
            frame_start <= en && bnd;
            if (en) begin
                frame_cnt <= fc_nxt;
                pitch_cnt <= pc_nxt;
                v_s       <= v_n;
                prate_s   <= pr_n;
                gain_s    <= g_n;
                exc_out   <= exc_n;
                vout      <= v_n;
            end
        end
    end

endmodule

// File: tb/tb_lpc_excitation_gen.sv
// tb_lpc_excitation_gen: directed-vector bench for lpc_excitation_gen
module tb_lpc_excitation_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        v = 1'b0;
    logic [15:0] pulserate = '0;
    logic [15:0] lpcrate = '0;
    logic [15:0] gain = '0;
    logic [15:0] exc_out;
    logic        exc_valid, vout, frame_start;

    int nvec = 0;
    int nerr = 0;

    // Noise samples for gain 0x7FFF from seed 0xACE1 (LFSR ACE1,E270,7138,389C,1C4E,0E27,B313,ED89)
    logic [15:0] noise_exp [8] = '{16'hACE1, 16'hE270, 16'h7137, 16'h389B,
                                   16'h1C4D, 16'h0E26, 16'hB313, 16'hED89};

    lpc_excitation_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .v           (v),
        .pulserate   (pulserate),
        .lpcrate     (lpcrate),
        .gain        (gain),
        .exc_out     (exc_out),
        .exc_valid   (exc_valid),
        .vout        (vout),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic e);
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) cyc(1'b0);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_exc", exc_out, 0);
        chk("rst_valid", exc_valid, 0);
        chk("rst_vout", vout, 0);
        chk("rst_fs", frame_start, 0);

        // Unvoiced, strobe every third cycle
        v = 1'b0; gain = 16'h7FFF; lpcrate = 16'd100; pulserate = 16'd4;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1);
            chk("uv_exc", exc_out, noise_exp[i]);
            chk("uv_valid", exc_valid, 1);
            chk("uv_vout", vout, 0);
            chk("uv_fs", frame_start, i == 0);
            cyc(1'b0);
            chk("uv_idle", exc_valid, 0);
            cyc(1'b0);
        end

        // Voiced basic
        do_reset();
        v = 1'b1; pulserate = 16'd4; lpcrate = 16'd240; gain = 16'h4000;
        for (int i = 0; i < 240; i++) begin
            cyc(1'b1);
            chk("vb_exc", exc_out, (i % 4 == 0) ? 32'h4000 : 32'h0);
            chk("vb_fs", frame_start, i == 0);
            chk("vb_vout", vout, 1);
            chk("vb_valid", exc_valid, 1);
        end
        cyc(1'b0);
        chk("vb_idle", exc_valid, 0);

        // Voiced -> voiced pitch change
        do_reset();
        v = 1'b1; lpcrate = 16'd10; gain = 16'h4000;
        for (int i = 0; i < 20; i++) begin
            pulserate = (i >= 10) ? 16'd3 : 16'd4;
            cyc(1'b1);
            chk("pc_exc", exc_out,
                (i == 0 || i == 4 || i == 8 || i == 12 || i == 15 || i == 18) ? 32'h4000 : 32'h0);
            chk("pc_fs", frame_start, i == 0 || i == 10);
        end

        // Unvoiced -> voiced
        do_reset();
        lpcrate = 16'd8; pulserate = 16'd4; gain = 16'h4000;
        for (int i = 0; i < 12; i++) begin
            v = (i >= 8);
            cyc(1'b1);
            chk("uv2v_vout", vout, i >= 8);
            chk("uv2v_fs", frame_start, i == 0 || i == 8);
            if (i >= 8)
                chk("uv2v_exc", exc_out, (i == 8) ? 32'h4000 : 32'h0);
        end

        // Degenerate rates: every sample is a boundary and a pulse
        do_reset();
        v = 1'b1; lpcrate = 16'd0; pulserate = 16'd0;
        for (int i = 0; i < 6; i++) begin
            gain = 16'h0100 * 16'(i + 1);
            cyc(1'b1);
            chk("dg_exc", exc_out, 32'h0100 * (i + 1));
            chk("dg_fs", frame_start, 1);
        end

        // Reset in the middle of a frame
        do_reset();
        v = 1'b0; gain = 16'h7FFF; lpcrate = 16'd240;
        for (int i = 0; i < 5; i++) cyc(1'b1);
        rst = 1'b0;
        cyc(1'b1);
        chk("mr_exc", exc_out, 0);
        chk("mr_valid", exc_valid, 0);
        chk("mr_vout", vout, 0);
        chk("mr_fs", frame_start, 0);
        rst = 1'b1;
        cyc(1'b1);
        chk("mr_fs1", frame_start, 1);
        chk("mr_exc1", exc_out, 32'hACE1);
        cyc(1'b1);
        chk("mr_fs2", frame_start, 0);
        chk("mr_exc2", exc_out, 32'hE270);
        cyc(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lpc_excitation_gen.md
Name: lpc_excitation_gen

Overview:
Parametrised LPC excitation source, successor to pulsegen. Emits one signed excitation sample per sample strobe. Voiced frames produce a gain-scaled impulse train at the pitch period; unvoiced frames produce gain-scaled LFSR noise. Voicing, pitch and gain are latched only at frame boundaries. Output feeds the LPC synthesis (all-pole) filter.

Parameters:
DATA_W, 16, excitation sample and gain width (signed Q1.(DATA_W-1))
CNT_W, 16, width of pitch and frame counters
LFSR_W, 16, noise LFSR length (taps from package table; 16 or 24 supported)
LFSR_SEED, 16'hACE1, LFSR reset state; must be nonzero

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
en  in  1  sample strobe, one cycle wide; all state advances only when en=1
v  in  1  voicing request (1 = voiced), sampled at frame boundary
pulserate  in  CNT_W  pitch period in samples, sampled at frame boundary
lpcrate  in  CNT_W  frame length in samples, sampled at frame boundary
gain  in  DATA_W  signed excitation gain, sampled at frame boundary; only values >= 0 are legal
exc_out  out  DATA_W  signed excitation sample
exc_valid  out  1  one-cycle strobe; exc_out is new
vout  out  1  voicing of the frame currently being emitted
frame_start  out  1  one-cycle strobe coincident with exc_valid on the first sample of each frame

Behaviour:
- Reset (rst=0 at posedge): exc_out=0, exc_valid=0, vout=0, frame_start=0. frame_cnt=0, pitch_cnt=0, LFSR=LFSR_SEED, shadow regs (v_s, prate_s, frate_s, gain_s)=0. The first en after reset is a frame boundary.
- Latency: exactly 1 cycle. en at cycle n -> exc_out/exc_valid/frame_start valid at cycle n+1. exc_valid=0 in every cycle without a preceding en.
- Frame counter: frame boundary when en=1 and frame_cnt==0.
  - At a boundary: latch v, pulserate, lpcrate and gain into the shadow regs; reload frame_cnt=max(lpcrate,1)-1.
  - Otherwise frame_cnt decrements on each en.
  - lpcrate=0 is treated as 1 (every sample is a boundary).
- Pitch counter, voiced mode:
  - pulse when pitch_cnt==0, then reload pitch_cnt=max(prate_s,1)-1; otherwise decrement on each en.
  - pulserate 0 or 1 gives a pulse every sample.
  - Pulse sample = gain_s; non-pulse sample = 0.
- Voicing transitions at a boundary:
  - unvoiced->voiced: pitch_cnt forced to 0, so the first voiced sample is a pulse.
  - voiced->voiced: pitch phase continues. The counter in flight finishes its current period before the new prate_s takes effect on reload.
  - voiced->unvoiced: pitch_cnt is held.
- Unvoiced mode: exc_out = sat((lfsr_s * gain_s) >>> (DATA_W-1)).
  - lfsr_s is the low DATA_W bits of the LFSR, read as signed.
  - The product is full width (2*DATA_W). Arithmetic right shift, then saturate to DATA_W signed range.
- LFSR: Galois, advances on every en regardless of voicing, so the noise sequence is independent of the voicing pattern. The all-zero state is unreachable; if detected, reload LFSR_SEED.
- vout = v_s for the emitted sample, updated together with exc_out.
- Simultaneous events: a boundary and a pitch pulse on the same en are both honoured. Latching happens first, and the sample uses the newly latched v_s/gain_s.
- Input changes between boundaries have no effect.
- Reset mid-frame aborts the frame immediately. No partial-state carry-over.

Decomposition:
- Package lpc_exc_pkg:
  - LFSR tap constants per supported LFSR_W (16: x^16+x^14+x^13+x^11+1; 24: x^24+x^23+x^22+x^17+1).
  - Default seed.
  - Saturation helper function.
  - Typedef for the signed sample of DATA_W.
- One sub-module: lfsr_noise (clk, rst, en, lfsr_out), instantiated once. Counters, shadow regs and the output mux stay in the top module.

Test Plan:
- Voiced, basic: DATA_W=16; reset 3 cycles; v=1, pulserate=4, lpcrate=240, gain=16'h4000, en every cycle for 240 cycles.
  -> Pulses of 0x4000 at samples 0,4,...,236 (60 pulses), 0 elsewhere.
  -> frame_start only on sample 0; vout=1; first exc_valid one cycle after first en.
- Unvoiced: v=0, gain=16'h7FFF, en every 3rd cycle.
  -> exc_out tracks the LFSR sequence from seed 0xACE1, one step per en; nonzero; no pulses.
  -> exc_valid exactly 1 cycle after each en; vout=0.
- Voiced->voiced pitch change: lpcrate=10, pulserate=4 in frame 0, pulserate=3 from frame 1.
  -> Pulses at samples 0,4,8, then 12 (old period finishes), then 15,18.
- Unvoiced->voiced: frame 0 v=0, frame 1 v=1, lpcrate=8.
  -> Pulse exactly on sample 8 with frame_start=1; vout changes 0->1 on that sample.
- Degenerate rates: lpcrate=0, pulserate=0, v=1.
  -> frame_start and a pulse on every sample.
  -> gain changed every sample is reflected on the very next sample.
- Reset mid-frame: assert rst=0 at sample 5 of a 240-sample frame.
  -> All outputs 0 on the next cycle.
  -> After release, the first en is a frame boundary and the LFSR restarts at 0xACE1.
